// File: rtl/div_sequencer.sv
// Control/operand-forwarding sequencer for a 16-bit Goldschmidt divider datapath.
// Define DIV_SEQ_SEED_ROM_EN to take the 1/D seed from an internal ROM instead of i_ia_in.
module div_sequencer #(
  parameter int ITERS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_n_in,
  input  logic [15:0] i_d_in,
  input  logic [15:0] i_ia_in,
  input  logic [15:0] i_result,
  output logic        o_k_sel,
  output logic        o_nd_sel,
  output logic [15:0] o_n_out,
  output logic [15:0] o_d_out,
  output logic [15:0] o_ia_out,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_quotient
);

  // state      | meaning
  // S_IDLE     | waiting for start; operand ports show latched values
  // S_ISSUE_D  | issue D_i to the datapath (K loads)
  // S_ISSUE_N  | issue N_i to the datapath (K holds)
  // S_DRAIN    | two cycles waiting for N_ITERS to emerge
  // S_DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_D = 3'd1,
    S_ISSUE_N = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_n;
  logic [15:0] r_d;
  logic [15:0] r_ia;
  logic [15:0] r_quotient;
  logic        r_err;
  logic [3:0]  r_iter;
  logic        r_drain;
  logic        w_accept;
  logic        w_d_norm;
  logic        w_last_iter;
  logic [15:0] w_seed;

  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_d_norm    = i_d_in[15];
  assign w_last_iter = (r_iter == 4'(ITERS - 1));

`ifdef DIV_SEQ_SEED_ROM_EN
  // round(2^15 / (1 + (k + 0.5)/8)), indexed by the three bits below the leading one
  always_comb begin
    w_seed = 16'h7878;
    case (i_d_in[14:12])
      3'd0:    w_seed = 16'h7878;
      3'd1:    w_seed = 16'h6BCA;
      3'd2:    w_seed = 16'h6186;
      3'd3:    w_seed = 16'h590B;
      3'd4:    w_seed = 16'h51EC;
      3'd5:    w_seed = 16'h4BDA;
      3'd6:    w_seed = 16'h469F;
      default: w_seed = 16'h4211;
    endcase
  end
`else
  assign w_seed = i_ia_in;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_nxt = w_d_norm ? S_ISSUE_D : S_DONE;
      S_ISSUE_D: w_state_nxt = S_ISSUE_N;
      S_ISSUE_N: w_state_nxt = w_last_iter ? S_DRAIN : S_ISSUE_D;
      S_DRAIN:   if (r_drain) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n        <= '0;
      r_d        <= '0;
      r_ia       <= '0;
      r_quotient <= '0;
      r_err      <= 1'b0;
      r_iter     <= '0;
      r_drain    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n     <= i_n_in;
        r_d     <= i_d_in;
        r_ia    <= w_seed;
        r_iter  <= '0;
        r_drain <= 1'b0;
        r_err   <= ~w_d_norm;
        if (!w_d_norm) r_quotient <= 16'hFFFF;
      end
      if (r_state == S_ISSUE_N) r_iter <= r_iter + 4'd1;
      if (r_state == S_DRAIN) begin
        r_drain <= ~r_drain;
        if (r_drain) r_quotient <= i_result;
      end
    end
  end

  // Iterations after the first take their operands straight off the datapath result bus
  always_comb begin
    o_k_sel  = 1'b0;
    o_nd_sel = 1'b0;
    o_n_out  = r_n;
    o_d_out  = r_d;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (r_state)
      S_ISSUE_D: begin
        o_busy = 1'b1;
        if (r_iter != 4'd0) begin
          o_k_sel = 1'b1;
          o_d_out = i_result;
        end
      end
      S_ISSUE_N: begin
        o_busy   = 1'b1;
        o_nd_sel = 1'b1;
        if (r_iter != 4'd0) o_n_out = i_result;
      end
      S_DRAIN: begin
        o_busy   = 1'b1;
        o_nd_sel = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_ia_out   = r_ia;
  assign o_err      = r_err;
  assign o_quotient = r_quotient;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Control and operand-forwarding sequencer for the 16-bit Goldschmidt divider. It sits directly upstream of the divider datapath and accepts a start handshake with N and D. It drives the datapath's kSelect/ndSelect/N/D/IA inputs each cycle and forwards the datapath's rounded `result` back as the next iteration's operands. It captures the final quotient and signals completion.

## Interface
- `ITERS`, default 4: Goldschmidt iterations, legal 1..8.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `start` in 1: request; sampled only in IDLE.
- `n_in` in 16: dividend, unsigned Q1.15.
- `d_in` in 16: divisor, unsigned Q1.15, must be normalized (bit15=1).
- `ia_in` in 16: external initial approximation of 1/D, Q1.15.
- `result` in 16: datapath rounded product, Q1.15.
- `k_sel` out 1: datapath kSelect; 0 = seed IA, 1 = derive K from `result`.
- `nd_sel` out 1: datapath ndSelect; 0 = D path (K register loads), 1 = N path (K holds).
- `n_out` out 16: datapath N operand.
- `d_out` out 16: datapath D operand.
- `ia_out` out 16: datapath IA.
- `busy` out 1: high from the acceptance edge until `done`.
- `done` out 1: one-cycle pulse; `quotient`/`err` valid.
- `err` out 1: divisor not normalized.
- `quotient` out 16: final N iterate, held until the next accepted start.

## Operation
- FSM states: IDLE, ISSUE_D, ISSUE_N, DRAIN, DONE.
- IDLE: `nd_sel`=0, `k_sel`=0, `busy`=0.
  - When `start`=1, latch `n_in`, `d_in` and the seed into internal registers.
  - If `d_in[15]`=0, go to DONE with `err`=1 and `quotient`=0xFFFF.
  - Otherwise, clear iteration counter i and go to ISSUE_D.
- ISSUE_D (iteration i): `nd_sel`=0.
  - i=0: `k_sel`=0, `d_out`=latched D.
  - i>0: `k_sel`=1, `d_out`=`result` (combinational forward of D_i).
- ISSUE_N (iteration i): `nd_sel`=1, `k_sel`=0.
  - `n_out` = latched N when i=0, otherwise `result`.
  - Increment i. If i==ITERS, go to DRAIN; otherwise go to ISSUE_D.
- DRAIN: two cycles, tracked by a 1-bit counter. No new issue; `nd_sel`=1.
  - At the end of the second DRAIN cycle, `quotient` <= `result` (N_ITERS).
  - Go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then return to IDLE. `start` is ignored in DONE.
- Outputs are combinational from state and registers. When a port is not in use, `n_out`/`d_out` drive the latched operands.
- `ia_out` is driven continuously from the latched seed.
- `start` is ignored while busy.

## Timing
- Datapath contract: an operand issued in cycle t appears on `result` in cycle t+2.
- Schedule, with cycle 0 being the first cycle after the acceptance edge:
  - D issued in cycle 2i, N issued in cycle 2i+1.
  - D_{i+1} appears on `result` in cycle 2i+2, exactly when ISSUE_D of i+1 forwards it.
  - N_{i+1} appears in cycle 2i+3.
- Throughput: 2 cycles per iteration, no bubbles.
- `quotient` is captured at the end of cycle 2·ITERS+1. `done` is high in cycle 2·ITERS+2 (cycle 10 for ITERS=4).
- Error path: `done` is high in cycle 0.
- Reset values: FSM=IDLE, counters 0.
  - `k_sel`=0, `nd_sel`=0, `busy`=0, `done`=0, `err`=0.
  - `quotient`=0, `n_out`=`d_out`=`ia_out`=0.
- Reset asserted mid-operation: immediate return to IDLE, no `done` pulse. The datapath pipeline contents are discarded.
- `start` held high through DONE: the next division is accepted on the first IDLE cycle. `err` is cleared on acceptance.

## Configuration
- `DIV_SEQ_SEED_ROM_EN` defined: `ia_in` is ignored. The seed comes from an internal 8-entry ROM indexed by `d_in[14:12]`, holding round(2^15/(1+(k+0.5)/8)):
  - 0x7878, 0x6BCA, 0x6186, 0x590B, 0x51EC, 0x4BDA, 0x469F, 0x4211.
- Not defined: the seed is `ia_in`, latched at acceptance. The `ia_in` port exists in both builds.

## Test plan
- ITERS=4, N=0x8000, D=0x8000, ROM enabled -> `ia_out`=0x7878.
  - `nd_sel` pattern 0,1,0,1,0,1,0,1 in cycles 0-7.
  - `k_sel`=0 only in cycle 0, then 1 on each D issue.
  - `done` in cycle 10, `quotient` within 1 ulp of 0x8000.
- N=0xC000, D=0x8000 with a behavioural datapath model -> `quotient` within 1 ulp of 0xC000.
  - Check `d_out`==`result` in cycles 2, 4, 6.
- D=0x4000 (unnormalized) -> `done` in cycle 0, `err`=1, `quotient`=0xFFFF, no D/N issue cycles.
- `start` pulsed in cycles 3 and 5 of a run -> ignored; exactly one `done`.
  - `start` held through DONE -> second run begins the next cycle with `err`=0.
- `reset`=0 in cycle 4 -> all outputs at reset values immediately, no `done`.
  - A following start completes normally.
- ROM disabled, `ia_in`=0x6000 -> `ia_out`=0x6000 from cycle 0 through DONE.
  - `ia_in` changed mid-run has no effect.
